// File: rtl/regfiletmp_ctrl_pkg.sv
// Shared types and constants for the temporary register file controller.
// Entry layout: rd[72:68] pc[67:36] type[35:34] spec_data[33:2] spec_valid[1] valid[0].
package regfiletmp_ctrl_pkg;

  localparam int unsigned ENTRY_W = 73;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned PTR_W   = 5;
  localparam int unsigned CNT_W   = 6;

  localparam int unsigned RD_MSB         = 72;
  localparam int unsigned RD_LSB         = 68;
  localparam int unsigned PC_MSB         = 67;
  localparam int unsigned PC_LSB         = 36;
  localparam int unsigned TYPE_MSB       = 35;
  localparam int unsigned TYPE_LSB       = 34;
  localparam int unsigned SPEC_DATA_MSB  = 33;
  localparam int unsigned SPEC_DATA_LSB  = 2;
  localparam int unsigned SPEC_VALID_BIT = 1;
  localparam int unsigned VALID_BIT      = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  itype;
    logic [31:0] spec_data;
    logic        spec_valid;
    logic        valid;
  } entry_t;

  typedef enum logic [1:0] {
    WrNone,
    WrNew,
    WrUpdate
  } wr_kind_e;

  function automatic entry_t make_new_entry(logic [4:0] rd, logic [31:0] pc, logic [1:0] itype);
    entry_t e;
    e       = '0;
    e.rd    = rd;
    e.pc    = pc;
    e.itype = itype;
    e.valid = 1'b1;
    return e;
  endfunction

  // Update words carry only the speculative result; the file merges them into the entry.
  function automatic entry_t make_update_entry(logic [31:0] data);
    entry_t e;
    e            = '0;
    e.spec_data  = data;
    e.spec_valid = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/regfiletmp_ctrl_arb.sv
// Write-port arbiter: CDB has priority, dispatch takes over after STARVE_LIMIT
// consecutive denied cycles.
module rft_arb #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic req_disp,
  input  logic req_cdb,
  input  logic hold,
  input  logic clear,
  output logic grant_disp,
  output logic grant_cdb
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  logic          disp_pri;

  assign disp_pri   = (starve_q >= LIMIT);
  assign grant_disp = disp_pri | ~req_cdb;
  assign grant_cdb  = ~(disp_pri & req_disp);

  always_comb begin
    starve_d = starve_q;
    if (clear) begin
      starve_d = '0;
    end else if (!hold && req_disp) begin
      if (grant_disp) begin
        starve_d = '0;
      end else if (!disp_pri) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/regfiletmp_ctrl.sv
// Sequencing controller for the 32-entry speculative temporary register file.
// Optional stale-tag window check: define REGFILETMP_CTRL_TAG_CHECK_EN.
module regfiletmp_ctrl
  import regfiletmp_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         disp_valid,
  output logic         disp_ready,
  input  logic [4:0]   disp_rd_reg,
  input  logic [31:0]  disp_pc,
  input  logic [1:0]   disp_inst_type,
  output logic [4:0]   disp_tag,
  input  logic         cdb_valid,
  output logic         cdb_ready,
  input  logic [4:0]   cdb_tag,
  input  logic [31:0]  cdb_data,
  output logic [4:0]   head_addr,
  input  logic [72:0]  head_entry,
  output logic         commit_valid,
  input  logic         commit_ready,
  output logic [4:0]   commit_rd_reg,
  output logic [31:0]  commit_pc,
  output logic [31:0]  commit_data,
  input  logic         flush,
  output logic [72:0]  rf_data_in,
  output logic [4:0]   rf_waddr,
  output logic         rf_new_entry,
  output logic         rf_update_entry,
  output logic         rf_flush,
  output logic [5:0]   count,
  output logic         full,
  output logic         empty,
  output logic         err_stale_tag
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rf_flush_q;
  logic             active_q;

  logic     flush_busy, hs_en;
  logic     grant_disp, grant_cdb;
  logic     disp_fire, cdb_fire, commit_fire, cdb_write;
  wr_kind_e wr_kind;
  entry_t   new_e, upd_e;

  // Handshakes stay low until the first edge after reset release.
  assign flush_busy = flush | rf_flush_q;
  assign hs_en      = active_q & ~flush_busy;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign disp_tag  = tail_q;
  assign head_addr = head_q;
  assign rf_flush  = rf_flush_q;

  rft_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_disp  (disp_valid & ~full),
    .req_cdb   (cdb_valid),
    .hold      (~hs_en),
    .clear     (flush),
    .grant_disp(grant_disp),
    .grant_cdb (grant_cdb)
  );

  assign disp_ready   = grant_disp & ~full & hs_en;
  assign cdb_ready    = grant_cdb & hs_en;
  assign commit_valid = ~empty & head_entry[VALID_BIT] & head_entry[SPEC_VALID_BIT] & hs_en;

  assign disp_fire   = disp_valid & disp_ready;
  assign cdb_fire    = cdb_valid & cdb_ready;
  assign commit_fire = commit_valid & commit_ready;

  assign commit_rd_reg = head_entry[RD_MSB:RD_LSB];
  assign commit_pc     = head_entry[PC_MSB:PC_LSB];
  assign commit_data   = head_entry[SPEC_DATA_MSB:SPEC_DATA_LSB];

  logic unused_head_type;
  assign unused_head_type = ^head_entry[TYPE_MSB:TYPE_LSB];

`ifdef REGFILETMP_CTRL_TAG_CHECK_EN
  logic [PTR_W-1:0] tag_off;
  logic             in_window;
  logic             err_q;

  // Distance from head, modulo depth, must fall inside the occupied count.
  assign tag_off   = cdb_tag - head_q;
  assign in_window = ({1'b0, tag_off} < count_q);
  assign cdb_write = cdb_fire & in_window;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= cdb_fire & ~in_window;
    end
  end

  assign err_stale_tag = err_q;
`else
  assign cdb_write     = cdb_fire;
  assign err_stale_tag = 1'b0;
`endif

  assign new_e = make_new_entry(disp_rd_reg, disp_pc, disp_inst_type);
  assign upd_e = make_update_entry(cdb_data);

  always_comb begin
    wr_kind = WrNone;
    if (disp_fire) begin
      wr_kind = WrNew;
    end else if (cdb_write) begin
      wr_kind = WrUpdate;
    end
  end

  always_comb begin
    rf_data_in      = '0;
    rf_waddr        = '0;
    rf_new_entry    = 1'b0;
    rf_update_entry = 1'b0;
    unique case (wr_kind)
      WrNew: begin
        rf_data_in   = new_e;
        rf_waddr     = tail_q;
        rf_new_entry = 1'b1;
      end
      WrUpdate: begin
        rf_data_in      = upd_e;
        rf_waddr        = cdb_tag;
        rf_update_entry = 1'b1;
      end
      default: begin
        rf_new_entry = 1'b0;
      end
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (disp_fire) begin
        tail_d = tail_q + 1'b1;
      end
      if (commit_fire) begin
        head_d = head_q + 1'b1;
      end
      case ({disp_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rf_flush_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rf_flush_q <= flush;
      active_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfiletmp_ctrl.sv
// Scoreboard bench for regfiletmp_ctrl with a behavioural model of the register file.
module tb_regfiletmp_ctrl;

  logic        clock, reset;
  logic        disp_valid, disp_ready;
  logic [4:0]  disp_rd_reg;
  logic [31:0] disp_pc;
  logic [1:0]  disp_inst_type;
  logic [4:0]  disp_tag;
  logic        cdb_valid, cdb_ready;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [4:0]  head_addr;
  logic [72:0] head_entry;
  logic        commit_valid, commit_ready;
  logic [4:0]  commit_rd_reg;
  logic [31:0] commit_pc, commit_data;
  logic        flush;
  logic [72:0] rf_data_in;
  logic [4:0]  rf_waddr;
  logic        rf_new_entry, rf_update_entry, rf_flush;
  logic [5:0]  count;
  logic        full, empty, err_stale_tag;

  regfiletmp_ctrl #(.STARVE_LIMIT(3)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd_reg(disp_rd_reg),
    .disp_pc(disp_pc), .disp_inst_type(disp_inst_type), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .head_addr(head_addr), .head_entry(head_entry),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_rd_reg(commit_rd_reg),
    .commit_pc(commit_pc), .commit_data(commit_data), .flush(flush),
    .rf_data_in(rf_data_in), .rf_waddr(rf_waddr), .rf_new_entry(rf_new_entry),
    .rf_update_entry(rf_update_entry), .rf_flush(rf_flush),
    .count(count), .full(full), .empty(empty), .err_stale_tag(err_stale_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        upd;
    logic [4:0]  addr;
    logic [72:0] data;
  } wr_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] data;
  } cm_t;

  wr_t wq[$];
  cm_t cq[$];
  int  n_pass = 0;
  int  n_total = 0;

  // Register file model: full write on allocate, merge of spec fields on update.
  logic [72:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = '0;
  assign head_entry = mem[head_addr];
  always @(posedge clock) begin
    if (rf_new_entry) mem[rf_waddr] <= rf_data_in;
    else if (rf_update_entry) mem[rf_waddr][33:1] <= rf_data_in[33:1];
    if (rf_flush) for (int i = 0; i < 32; i++) mem[i][0] <= 1'b0;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every write or commit the DUT presents must match the head of its queue.
  always @(negedge clock) begin
    if (reset) begin
      chk("wr_onehot", 128'(rf_new_entry & rf_update_entry), 128'(0));
      if (rf_new_entry || rf_update_entry) begin
        if (wq.size() == 0) begin
          n_total++;
          $display("FAIL wr_unexpected: got write addr %0d data %0h, expected none",
                   rf_waddr, rf_data_in);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr", 128'({rf_update_entry, rf_waddr, rf_data_in}), 128'(e));
        end
      end
      if (commit_valid && commit_ready) begin
        if (cq.size() == 0) begin
          n_total++;
          $display("FAIL commit_unexpected: got rd %0d pc %0h, expected none",
                   commit_rd_reg, commit_pc);
        end else begin
          cm_t c;
          c = cq.pop_front();
          chk("commit", 128'({commit_rd_reg, commit_pc, commit_data}), 128'(c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  function automatic logic [72:0] new_word(logic [4:0] rd, logic [31:0] pc, logic [1:0] t);
    return {rd, pc, t, 32'h0, 1'b0, 1'b1};
  endfunction

  function automatic logic [72:0] upd_word(logic [31:0] d);
    return {39'h0, d, 1'b1, 1'b0};
  endfunction

  task automatic set_disp(input logic v, input logic [4:0] rd, input logic [31:0] pc,
                          input logic [1:0] t);
    disp_valid = v; disp_rd_reg = rd; disp_pc = pc; disp_inst_type = t;
  endtask

  task automatic set_cdb(input logic v, input logic [4:0] tag, input logic [31:0] d);
    cdb_valid = v; cdb_tag = tag; cdb_data = d;
  endtask

  logic [4:0] exp_tail;

  initial begin
    reset = 1'b0; flush = 1'b0; commit_ready = 1'b0;
    set_disp(0, 0, 0, 0);
    set_cdb(0, 0, 0);
    tick(); tick();
    mid();
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_tag", 128'(disp_tag), 128'(0));
    chk("rst_head", 128'(head_addr), 128'(0));
    chk("rst_rf_flush", 128'(rf_flush), 128'(0));
    chk("rst_err", 128'(err_stale_tag), 128'(0));
    chk("rst_hs", 128'({disp_ready, cdb_ready, commit_valid, rf_new_entry}), 128'(0));
    tick();
    reset = 1'b1;
    tick();

    // Three allocations in order.
    for (int i = 0; i < 3; i++) begin
      set_disp(1, 5'(i + 1), 32'h1000 + 32'(4 * i), 2'(i));
      wq.push_back('{1'b0, 5'(i), new_word(5'(i + 1), 32'h1000 + 32'(4 * i), 2'(i))});
      mid();
      chk("alloc_ready", 128'(disp_ready), 128'(1));
      chk("alloc_tag", 128'(disp_tag), 128'(i));
      tick();
    end
    disp_valid = 1'b0;
    mid();
    chk("alloc_count", 128'(count), 128'(3));
    chk("alloc_no_commit", 128'(commit_valid), 128'(0));

    // CDB result to the head, then retire it.
    tick();
    set_cdb(1, 0, 32'hDEADBEEF);
    wq.push_back('{1'b1, 5'd0, upd_word(32'hDEADBEEF)});
    mid();
    chk("cdb_ready", 128'(cdb_ready), 128'(1));
    chk("commit_not_yet", 128'(commit_valid), 128'(0));
    tick();
    cdb_valid = 1'b0;
    commit_ready = 1'b1;
    cq.push_back('{5'd1, 32'h1000, 32'hDEADBEEF});
    mid();
    chk("commit_valid", 128'(commit_valid), 128'(1));
    chk("commit_data", 128'(commit_data), 128'(32'hDEADBEEF));
    chk("commit_rd", 128'(commit_rd_reg), 128'(1));
    tick();
    commit_ready = 1'b0;
    mid();
    chk("head_after_commit", 128'(head_addr), 128'(1));
    chk("count_after_commit", 128'(count), 128'(2));

    // Contention: dispatch wins once every fourth cycle.
    tick();
    exp_tail = 5'd3;
    for (int c = 0; c < 8; c++) begin
      logic exp_d;
      exp_d = ((c % 4) == 3);
      set_disp(1, 5'(20 + c), 32'h2000 + 32'(c), 2'd1);
      set_cdb(1, 5'd1, 32'hC0DE0000 + 32'(c));
      if (exp_d) begin
        wq.push_back('{1'b0, exp_tail, new_word(5'(20 + c), 32'h2000 + 32'(c), 2'd1)});
        exp_tail = exp_tail + 5'd1;
      end else begin
        wq.push_back('{1'b1, 5'd1, upd_word(32'hC0DE0000 + 32'(c))});
      end
      mid();
      chk("starve_disp_ready", 128'(disp_ready), 128'(exp_d));
      chk("starve_cdb_ready", 128'(cdb_ready), 128'(!exp_d));
      tick();
    end
    set_disp(0, 0, 0, 0);
    set_cdb(0, 0, 0);
    mid();
    chk("starve_count", 128'(count), 128'(4));
    chk("head1_ready", 128'(commit_valid), 128'(1));

    // Fill to 32, tail wraps past 31.
    tick();
    exp_tail = 5'd5;
    for (int k = 0; k < 28; k++) begin
      set_disp(1, 5'(k), 32'h3000 + 32'(k), 2'd0);
      wq.push_back('{1'b0, exp_tail, new_word(5'(k), 32'h3000 + 32'(k), 2'd0)});
      mid();
      chk("fill_tag", 128'(disp_tag), 128'(exp_tail));
      chk("fill_ready", 128'(disp_ready), 128'(1));
      tick();
      exp_tail = exp_tail + 5'd1;
    end
    mid();
    chk("full", 128'(full), 128'(1));
    chk("full_count", 128'(count), 128'(32));
    chk("full_stall", 128'(disp_ready), 128'(0));
    chk("wrap_tag", 128'(disp_tag), 128'(1));
    tick();
    disp_valid = 1'b0;
    set_cdb(1, 5'd2, 32'h22222222);
    wq.push_back('{1'b1, 5'd2, upd_word(32'h22222222)});
    mid();
    chk("full_cdb_ready", 128'(cdb_ready), 128'(1));
    tick();
    set_cdb(0, 0, 0);
    set_disp(1, 5'd30, 32'h4000, 2'd2);
    commit_ready = 1'b1;
    cq.push_back('{5'd2, 32'h1004, 32'hC0DE0006});
    mid();
    chk("full_commit_stall", 128'(disp_ready), 128'(0));
    chk("full_commit_valid", 128'(commit_valid), 128'(1));
    tick();
    wq.push_back('{1'b0, 5'd1, new_word(5'd30, 32'h4000, 2'd2)});
    cq.push_back('{5'd3, 32'h1008, 32'h22222222});
    mid();
    chk("freed_slot_ready", 128'(disp_ready), 128'(1));
    chk("count_31", 128'(count), 128'(31));
    tick();
    disp_valid = 1'b0;
    commit_ready = 1'b0;
    mid();
    chk("both_count", 128'(count), 128'(31));
    chk("both_head", 128'(head_addr), 128'(3));
    chk("both_tail", 128'(disp_tag), 128'(2));

    // Flush, refill five, then flush against every handshake.
    tick();
    flush = 1'b1;
    mid();
    chk("flush_busy0", 128'(disp_ready), 128'(0));
    tick();
    flush = 1'b0;
    mid();
    chk("flush_pulse", 128'(rf_flush), 128'(1));
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_busy1", 128'(disp_ready), 128'(0));
    tick();
    mid();
    chk("flush_done", 128'({rf_flush, disp_ready}), 128'(2'b01));
    tick();
    for (int i = 0; i < 5; i++) begin
      set_disp(1, 5'(10 + i), 32'h5000 + 32'(4 * i), 2'd3);
      wq.push_back('{1'b0, 5'(i), new_word(5'(10 + i), 32'h5000 + 32'(4 * i), 2'd3)});
      tick();
    end
    disp_valid = 1'b0;
    set_cdb(1, 5'd0, 32'h55555555);
    wq.push_back('{1'b1, 5'd0, upd_word(32'h55555555)});
    tick();
    cdb_valid = 1'b0;
    mid();
    chk("five_count", 128'(count), 128'(5));
    chk("five_commit_valid", 128'(commit_valid), 128'(1));
    tick();
    flush = 1'b1;
    set_disp(1, 5'd9, 32'h6000, 2'd0);
    set_cdb(1, 5'd1, 32'h66666666);
    commit_ready = 1'b1;
    mid();
    chk("cflush_hs", 128'({disp_ready, cdb_ready, commit_valid}), 128'(0));
    chk("cflush_wr", 128'({rf_new_entry, rf_update_entry}), 128'(0));
    tick();
    flush = 1'b0;
    mid();
    chk("cflush_pulse", 128'(rf_flush), 128'(1));
    chk("cflush_count", 128'(count), 128'(0));
    chk("cflush_hs2", 128'({disp_ready, cdb_ready, commit_valid}), 128'(0));
    tick();
    set_disp(0, 0, 0, 0);
    set_cdb(0, 0, 0);
    commit_ready = 1'b0;
    mid();
    chk("cflush_end", 128'({rf_flush, head_addr, disp_tag}), 128'(0));

    // Tag outside [head, tail).
    tick();
    for (int i = 0; i < 3; i++) begin
      set_disp(1, 5'(i + 1), 32'h7000 + 32'(i), 2'd0);
      wq.push_back('{1'b0, 5'(i), new_word(5'(i + 1), 32'h7000 + 32'(i), 2'd0)});
      tick();
    end
    disp_valid = 1'b0;
    set_cdb(1, 5'd7, 32'h77777777);
`ifndef REGFILETMP_CTRL_TAG_CHECK_EN
    wq.push_back('{1'b1, 5'd7, upd_word(32'h77777777)});
`endif
    mid();
    chk("stale_ready", 128'(cdb_ready), 128'(1));
`ifdef REGFILETMP_CTRL_TAG_CHECK_EN
    chk("stale_no_write", 128'(rf_update_entry), 128'(0));
`else
    chk("stale_written", 128'(rf_update_entry), 128'(1));
`endif
    tick();
    set_cdb(1, 5'd2, 32'h12345678);
    wq.push_back('{1'b1, 5'd2, upd_word(32'h12345678)});
    mid();
`ifdef REGFILETMP_CTRL_TAG_CHECK_EN
    chk("stale_err", 128'(err_stale_tag), 128'(1));
`else
    chk("stale_err", 128'(err_stale_tag), 128'(0));
`endif
    tick();
    cdb_valid = 1'b0;
    mid();
    chk("in_window_err", 128'(err_stale_tag), 128'(0));
    chk("pre_reset_count", 128'(count), 128'(3));

    // Asynchronous reset mid-operation.
    tick();
    reset = 1'b0;
    #1;
    chk("async_count", 128'(count), 128'(0));
    chk("async_tag", 128'({disp_tag, head_addr}), 128'(0));
    chk("async_rf_flush", 128'(rf_flush), 128'(0));
    tick();
    reset = 1'b1;
    tick();

    chk("wq_drained", 128'(wq.size()), 128'(0));
    chk("cq_drained", 128'(cq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
